// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph constants and digit code type for the seven-segment mux
package seg_pkg;

    typedef logic [3:0] code_t;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;
    localparam logic [6:0] GLYPH_A   = 7'b0001000;
    localparam logic [6:0] GLYPH_B   = 7'b0000011;
    localparam logic [6:0] GLYPH_C   = 7'b1000110;
    localparam logic [6:0] GLYPH_D   = 7'b0100001;
    localparam logic [6:0] GLYPH_E   = 7'b0000110;
    localparam logic [6:0] GLYPH_F   = 7'b0001110;
    localparam logic [6:0] GLYPH_ERR = 7'b0001110;

endpackage

// File: rtl/seg_glyph_rom.sv
// rtl/seg_glyph_rom.sv - combinational digit code to active-low segment pattern
module seg_glyph_rom
    import seg_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  code_t      code_i,
    output logic [6:0] seg_o
);

    localparam bit HEX = (HEX_MODE != 0);

    always_comb begin
        seg_o = GLYPH_ERR;
        case (code_i)
            4'd0:  seg_o = GLYPH_0;
            4'd1:  seg_o = GLYPH_1;
            4'd2:  seg_o = GLYPH_2;
            4'd3:  seg_o = GLYPH_3;
            4'd4:  seg_o = GLYPH_4;
            4'd5:  seg_o = GLYPH_5;
            4'd6:  seg_o = GLYPH_6;
            4'd7:  seg_o = GLYPH_7;
            4'd8:  seg_o = GLYPH_8;
            4'd9:  seg_o = GLYPH_9;
            // Without hex glyphs, codes above 9 fall through to the error pattern.
            4'd10: seg_o = HEX ? GLYPH_A : GLYPH_ERR;
            4'd11: seg_o = HEX ? GLYPH_B : GLYPH_ERR;
            4'd12: seg_o = HEX ? GLYPH_C : GLYPH_ERR;
            4'd13: seg_o = HEX ? GLYPH_D : GLYPH_ERR;
            4'd14: seg_o = HEX ? GLYPH_E : GLYPH_ERR;
            4'd15: seg_o = HEX ? GLYPH_F : GLYPH_ERR;
            default: seg_o = GLYPH_ERR;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - time-multiplexed common-anode seven-segment scanner with frame-aligned updates
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW    = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic                  phase_q, phase_d;
    logic [DW-1:0]         active_q, active_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  fd_q, fd_d;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic [NUM_DIGITS-1:0] dark;
    code_t                 cur_code;
    logic [6:0]            glyph;

    assign slot_end   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        blk_d   = blk_q;
        phase_d = phase_q;
        if (frame_wrap) begin
            idx_d = '0;
            if (blk_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end else if (slot_end) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Active only ever changes on a frame wrap, so a frame is never mixed.
    always_comb begin
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (load && frame_wrap) begin
            active_d     = digits_in;
            pend_valid_d = 1'b0;
        end else begin
            if (frame_wrap && pend_valid_q) begin
                active_d     = pend_q;
                pend_valid_d = 1'b0;
            end
            if (load) begin
                pend_d       = digits_in;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Walk down from the most significant digit while the run of zeros holds.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (active_q[4*i +: 4] == 4'd0);
            lz_dark[i] = lz_suppress && zero_run;
        end
    end

    assign dark     = blank_mask | (blink_mask & {NUM_DIGITS{phase_q}}) | lz_dark;
    assign cur_code = code_t'(active_q >> (4 * idx_q));

    seg_glyph_rom #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph_rom (
        .code_i (cur_code),
        .seg_o  (glyph)
    );

    always_comb begin
        seg_d = SEG_OFF;
        en_d  = '1;
        fd_d  = frame_wrap;
        if ((cnt_q >= CNT_W'(GUARD)) && !dark[idx_q]) begin
            seg_d = glyph;
            en_d  = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            blk_q        <= '0;
            phase_q      <= 1'b0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_OFF;
            en_q         <= '1;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            blk_q        <= blk_d;
            phase_q      <= phase_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
            fd_q         <= fd_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_en     = en_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - randomized and directed bench against a cycle-count reference model
module tb_seg_display_mux;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GD = 2;
    localparam int BF = 2;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        lz = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink = '0;

    logic [6:0]  seg_h, seg_d;
    logic [3:0]  en_h, en_d;
    logic        fd_h, fd_d;

    seg_display_mux #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD), .BLINK_FRAMES(BF), .HEX_MODE(1)
    ) u_hex (
        .clk(clk), .rst_n(rst_n), .digits_in(din), .load(load),
        .blank_mask(blank), .blink_mask(blink), .lz_suppress(lz),
        .seg_out(seg_h), .dig_en(en_h), .frame_done(fd_h)
    );

    seg_display_mux #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD), .BLINK_FRAMES(BF), .HEX_MODE(0)
    ) u_dec (
        .clk(clk), .rst_n(rst_n), .digits_in(din), .load(load),
        .blank_mask(blank), .blink_mask(blink), .lz_suppress(lz),
        .seg_out(seg_d), .dig_en(en_d), .frame_done(fd_d)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          n_checks = 0;
    int          n_fail = 0;
    int          st = 0;
    logic [15:0] m_act = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, st);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input int code, input bit hex);
        if (code < 10 || hex) return glyph_tab[code];
        return 7'b0001110;
    endfunction

    function automatic bit ref_dark(input int i, input int s);
        bit phase;
        phase = ((s / FR) / BF) % 2 == 1;
        if (blank[i]) return 1'b1;
        if (blink[i] && phase) return 1'b1;
        if (lz && i != 0 && (m_act >> (4 * i)) == 16'd0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: predict the pins from the state before the edge, then advance the model.
    task automatic tick();
        int         cnt, idx;
        logic [6:0] eh, ed;
        logic [3:0] ee, one;
        bit         efd, wrap;
        cnt  = st % RD;
        idx  = (st / RD) % ND;
        wrap = (st % FR) == FR - 1;
        efd  = wrap;
        if (cnt < GD || ref_dark(idx, st)) begin
            eh = 7'h7F;
            ed = 7'h7F;
            ee = 4'hF;
        end else begin
            eh  = ref_glyph(int'(m_act[4*idx +: 4]), 1'b1);
            ed  = ref_glyph(int'(m_act[4*idx +: 4]), 1'b0);
            one = 4'b0001 << idx;
            ee  = ~one;
        end
        @(posedge clk);
        if (load && wrap) begin
            m_act = din;
            m_pv  = 1'b0;
        end else begin
            if (wrap && m_pv) begin
                m_act = m_pend;
                m_pv  = 1'b0;
            end
            if (load) begin
                m_pend = din;
                m_pv   = 1'b1;
            end
        end
        st++;
        #1;
        check("seg_hex", seg_h, eh);
        check("seg_dec", seg_d, ed);
        check("dig_en_hex", en_h, ee);
        check("dig_en_dec", en_d, ee);
        check("frame_done", fd_h, efd);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FR && (st % FR) != pos; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        din  = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_seg"}, seg_h, 7'h7F);
        check({tag, "_en"}, en_h, 4'hF);
        check({tag, "_fd"}, fd_h, 1'b0);
        check({tag, "_en_dec"}, en_d, 4'hF);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_pins("reset");
        rst_n = 1'b1;

        run_to(5);
        do_load(16'h1234);
        run(2 * FR);

        lz = 1'b1;
        do_load(16'h0042);
        run(2 * FR);
        do_load(16'h0000);
        run(2 * FR);
        lz = 1'b0;

        do_load(16'hABCF);
        run(2 * FR);

        run_to(10);
        do_load(16'h1111);
        run(4);
        do_load(16'h2222);
        run(FR + 8);
        run_to(FR - 1);
        do_load(16'h5678);
        run(FR + 8);

        blink = 4'b0001;
        run(5 * FR);
        blink = 4'b0000;
        blank = 4'b1000;
        run(2 * FR);
        blank = 4'b0000;

        run_to(RD + 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_pins("async_rst");
        @(negedge clk);
        check_reset_pins("held_rst");
        rst_n  = 1'b1;
        st     = 0;
        m_act  = '0;
        m_pend = '0;
        m_pv   = 1'b0;
        run(FR + 4);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                din  = 16'($urandom);
                load = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) begin
                blank = 4'($urandom);
                blink = 4'($urandom);
                lz    = 1'($urandom);
            end
            tick();
            load = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
